// File: rtl/mips_pkg.sv
// Shared MIPS encodings used by the decode stage: opcodes, functs, ALU operations
// and the decoded control bundle together with its decoder function.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  LINK_REG  = 5'd31;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_kind_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_LINK} dst_kind_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    imm_kind_e  imm_kind;
    dst_kind_e  dst_kind;
    logic       reads_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_jump;
    logic       is_jr;
  } ctrl_t;

  // Anything not recognised falls through as an all-zero (NOP) control word.
  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reads_rt  = 1'b1;
        c.dst_kind  = DST_RD;
        case (funct)
          FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_XOR:  c.alu_op = ALU_XOR;
          FN_NOR:  c.alu_op = ALU_NOR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLL:  c.alu_op = ALU_SLL;
          FN_SRL:  c.alu_op = ALU_SRL;
          FN_SRA:  c.alu_op = ALU_SRA;
          FN_JR: begin
            c.reg_write = 1'b0;
            c.reads_rt  = 1'b0;
            c.is_jr     = 1'b1;
          end
          default: c = '0;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.dst_kind  = DST_RT;
        case (opcode)
          OP_SLTI: c.alu_op = ALU_SLT;
          OP_ANDI: begin c.alu_op = ALU_AND; c.imm_kind = IMM_ZEXT; end
          OP_ORI:  begin c.alu_op = ALU_OR;  c.imm_kind = IMM_ZEXT; end
          OP_XORI: begin c.alu_op = ALU_XOR; c.imm_kind = IMM_ZEXT; end
          OP_LUI:  begin c.alu_op = ALU_LUI; c.imm_kind = IMM_LUI;  end
          default: c.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.dst_kind   = DST_RT;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.reads_rt  = 1'b1;
        c.dst_kind  = DST_RT;
      end
      OP_BEQ, OP_BNE: begin
        c.alu_op   = ALU_SUB;
        c.reads_rt = 1'b1;
        c.is_beq   = (opcode == OP_BEQ);
        c.is_bne   = (opcode == OP_BNE);
      end
      OP_J: c.is_jump = 1'b1;
      OP_JAL: begin
        c.is_jump   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.dst_kind  = DST_LINK;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two asynchronous read ports with write-through bypass,
// one synchronous write port, register 0 hardwired to zero.
module reg_file #(
  parameter int LEN    = 32,
  parameter int NB_REG = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [NB_REG-1:0] i_waddr,
  input  logic [LEN-1:0]    i_wdata,
  input  logic [NB_REG-1:0] i_raddr_a,
  input  logic [NB_REG-1:0] i_raddr_b,
  output logic [LEN-1:0]    o_rdata_a,
  output logic [LEN-1:0]    o_rdata_b
);

  localparam int DEPTH = 2 ** NB_REG;

  logic [LEN-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write landing this cycle is visible to the reader in the same cycle.
  always_comb begin
    o_rdata_a = r_mem[i_raddr_a];
    if (i_raddr_a == '0)                        o_rdata_a = '0;
    else if (i_we && (i_waddr == i_raddr_a))    o_rdata_a = i_wdata;
  end

  always_comb begin
    o_rdata_b = r_mem[i_raddr_b];
    if (i_raddr_b == '0)                        o_rdata_b = '0;
    else if (i_we && (i_waddr == i_raddr_b))    o_rdata_b = i_wdata;
  end

endmodule

// File: rtl/seg_instruction_decode.sv
// MIPS instruction decode stage: IF/ID register, decoder, branch/jump resolution,
// hazard stall logic and the ID/EX register.
module seg_instruction_decode
  import mips_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int NB_REG   = 5,
  parameter int NB_ALUOP = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [LEN-1:0]      i_instruction,
  input  logic [LEN-1:0]      i_PC,
  input  logic                i_WB_RegWrite,
  input  logic [NB_REG-1:0]   i_WB_rd,
  input  logic [LEN-1:0]      i_WB_data,
  input  logic                i_EXMEM_RegWrite,
  input  logic [NB_REG-1:0]   i_EXMEM_rd,
  output logic [LEN-1:0]      o_PC_branch,
  output logic                o_PCSrc,
  output logic                o_PC_write,
  output logic [LEN-1:0]      o_rs_data,
  output logic [LEN-1:0]      o_rt_data,
  output logic [LEN-1:0]      o_imm,
  output logic [4:0]          o_shamt,
  output logic [NB_REG-1:0]   o_rs,
  output logic [NB_REG-1:0]   o_rt,
  output logic [NB_REG-1:0]   o_rd_dst,
  output logic                o_RegWrite,
  output logic                o_MemRead,
  output logic                o_MemWrite,
  output logic                o_MemtoReg,
  output logic                o_ALUSrc,
  output logic [NB_ALUOP-1:0] o_ALUOp,
  output logic [LEN-1:0]      o_PC_link
);

  logic [LEN-1:0]      r_ifid_instr, r_ifid_pc;
  logic [LEN-1:0]      r_rs_data, r_rt_data, r_imm, r_pc_link;
  logic [4:0]          r_shamt;
  logic [NB_REG-1:0]   r_rs, r_rt, r_rd_dst;
  logic                r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
  logic [NB_ALUOP-1:0] r_alu_op;

  logic [NB_REG-1:0] w_rs, w_rt, w_rd, w_dst;
  logic [4:0]        w_shamt;
  logic [15:0]       w_imm16;
  logic [LEN-1:0]    w_rs_data, w_rt_data, w_imm_sext, w_imm_ext, w_pc_plus1, w_target;
  ctrl_t             w_ctrl;
  logic              w_taken, w_load_use, w_idex_hit, w_exmem_hit, w_br_user, w_stall;

  assign w_rs       = r_ifid_instr[25:21];
  assign w_rt       = r_ifid_instr[20:16];
  assign w_rd       = r_ifid_instr[15:11];
  assign w_shamt    = r_ifid_instr[10:6];
  assign w_imm16    = r_ifid_instr[15:0];
  assign w_pc_plus1 = r_ifid_pc + LEN'(1);
  assign w_imm_sext = {{(LEN-16){w_imm16[15]}}, w_imm16};

  // The all-zero word is a true bubble rather than "SLL r0, r0, 0" with RegWrite set.
  always_comb begin
    w_ctrl = '0;
    if (r_ifid_instr != LEN'(NOP_INSTR)) w_ctrl = decode(r_ifid_instr[31:26], r_ifid_instr[5:0]);
  end

  reg_file #(.LEN(LEN), .NB_REG(NB_REG)) u_reg_file (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (i_WB_RegWrite),
    .i_waddr   (i_WB_rd),
    .i_wdata   (i_WB_data),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_data),
    .o_rdata_b (w_rt_data)
  );

  always_comb begin
    case (w_ctrl.imm_kind)
      IMM_ZEXT: w_imm_ext = {{(LEN-16){1'b0}}, w_imm16};
      IMM_LUI:  w_imm_ext = {w_imm16, {(LEN-16){1'b0}}};
      default:  w_imm_ext = w_imm_sext;
    endcase
    case (w_ctrl.dst_kind)
      DST_RT:   w_dst = w_rt;
      DST_LINK: w_dst = NB_REG'(LINK_REG);
      default:  w_dst = w_rd;
    endcase
  end

  always_comb begin
    w_target = w_pc_plus1 + w_imm_sext;
    if (w_ctrl.is_jr)        w_target = w_rs_data;
    else if (w_ctrl.is_jump) w_target = {w_pc_plus1[LEN-1:26], r_ifid_instr[25:0]};
  end

  assign w_taken = (w_ctrl.is_beq && (w_rs_data == w_rt_data)) ||
                   (w_ctrl.is_bne && (w_rs_data != w_rt_data)) ||
                   w_ctrl.is_jump || w_ctrl.is_jr;

  // Branches and JR compare in ID, so any in-flight producer of their sources must drain.
  assign w_br_user   = w_ctrl.is_beq || w_ctrl.is_bne || w_ctrl.is_jr;
  assign w_load_use  = r_mem_read && (r_rd_dst != '0) &&
                       ((r_rd_dst == w_rs) || (w_ctrl.reads_rt && (r_rd_dst == w_rt)));
  assign w_idex_hit  = r_reg_write && (r_rd_dst != '0) &&
                       ((r_rd_dst == w_rs) || (w_ctrl.reads_rt && (r_rd_dst == w_rt)));
  assign w_exmem_hit = i_EXMEM_RegWrite && (i_EXMEM_rd != '0) &&
                       ((i_EXMEM_rd == w_rs) || (w_ctrl.reads_rt && (i_EXMEM_rd == w_rt)));
  assign w_stall     = w_load_use || (w_br_user && (w_idex_hit || w_exmem_hit));

  assign o_PC_write  = !w_stall || !i_rst;
  assign o_PCSrc     = w_taken && !w_stall && i_rst;
  assign o_PC_branch = w_target;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (!w_stall) begin
      r_ifid_instr <= o_PCSrc ? LEN'(NOP_INSTR) : i_instruction;
      r_ifid_pc    <= o_PCSrc ? '0 : i_PC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || w_stall) begin
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd_dst     <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_pc_link    <= '0;
    end else begin
      r_rs_data    <= w_rs_data;
      r_rt_data    <= w_rt_data;
      r_imm        <= w_imm_ext;
      r_shamt      <= w_shamt;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_rd_dst     <= w_dst;
      r_reg_write  <= w_ctrl.reg_write;
      r_mem_read   <= w_ctrl.mem_read;
      r_mem_write  <= w_ctrl.mem_write;
      r_mem_to_reg <= w_ctrl.mem_to_reg;
      r_alu_src    <= w_ctrl.alu_src;
      r_alu_op     <= NB_ALUOP'(w_ctrl.alu_op);
      r_pc_link    <= w_pc_plus1;
    end
  end

  assign o_rs_data  = r_rs_data;
  assign o_rt_data  = r_rt_data;
  assign o_imm      = r_imm;
  assign o_shamt    = r_shamt;
  assign o_rs       = r_rs;
  assign o_rt       = r_rt;
  assign o_rd_dst   = r_rd_dst;
  assign o_RegWrite = r_reg_write;
  assign o_MemRead  = r_mem_read;
  assign o_MemWrite = r_mem_write;
  assign o_MemtoReg = r_mem_to_reg;
  assign o_ALUSrc   = r_alu_src;
  assign o_ALUOp    = r_alu_op;
  assign o_PC_link  = r_pc_link;

endmodule

// File: tb/tb_seg_instruction_decode.sv
// Directed testbench for the decode stage with hand-computed expectations.
module tb_seg_instruction_decode;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instruction, i_PC, i_WB_data;
  logic        i_WB_RegWrite, i_EXMEM_RegWrite;
  logic [4:0]  i_WB_rd, i_EXMEM_rd;
  logic [31:0] o_PC_branch, o_rs_data, o_rt_data, o_imm, o_PC_link;
  logic        o_PCSrc, o_PC_write;
  logic [4:0]  o_shamt, o_rs, o_rt, o_rd_dst;
  logic        o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc;
  logic [3:0]  o_ALUOp;

  int checks = 0;
  int errors = 0;

  seg_instruction_decode dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_PC(i_PC),
    .i_WB_RegWrite(i_WB_RegWrite), .i_WB_rd(i_WB_rd), .i_WB_data(i_WB_data),
    .i_EXMEM_RegWrite(i_EXMEM_RegWrite), .i_EXMEM_rd(i_EXMEM_rd),
    .o_PC_branch(o_PC_branch), .o_PCSrc(o_PCSrc), .o_PC_write(o_PC_write),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_shamt(o_shamt),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd_dst(o_rd_dst), .o_RegWrite(o_RegWrite),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_MemtoReg(o_MemtoReg),
    .o_ALUSrc(o_ALUSrc), .o_ALUOp(o_ALUOp), .o_PC_link(o_PC_link)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_instruction    = 32'h0;
    i_WB_RegWrite    = 1'b0;
    i_EXMEM_RegWrite = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_instruction    = $urandom;
      i_PC             = $urandom;
      i_WB_RegWrite    = 1'($urandom);
      i_WB_rd          = 5'($urandom);
      i_WB_data        = $urandom;
      i_EXMEM_RegWrite = 1'($urandom);
      i_EXMEM_rd       = 5'($urandom);
      tick();
    end
    checks++; if (o_PC_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b want 1", o_PC_write); end
    checks++; if (o_PCSrc !== 1'b0) begin errors++; $display("FAIL reset_pcsrc: got %b want 0", o_PCSrc); end
    checks++;
    if ({o_rs_data, o_rt_data, o_imm, o_PC_link} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want 0", o_rs_data, o_rt_data, o_imm, o_PC_link);
    end
    checks++;
    if ({o_shamt, o_rs, o_rt, o_rd_dst, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc, o_ALUOp} !== 29'h0) begin
      errors++; $display("FAIL reset_ctrl: got rd=%0d rw=%b mr=%b mw=%b alusrc=%b want 0", o_rd_dst, o_RegWrite, o_MemRead, o_MemWrite, o_ALUSrc);
    end
    i_rst = 1'b1;
    i_WB_rd = 5'd0; i_EXMEM_rd = 5'd0; i_WB_data = 32'h0;
    idle(2);
  endtask

  task automatic test_addi();
    i_instruction = 32'h2001FFFF; i_PC = 32'd4;
    tick();
    i_instruction = 32'h0;
    tick();
    checks++; if (o_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm: got %h want ffffffff", o_imm); end
    checks++; if (o_rd_dst !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0d want 1", o_rd_dst); end
    checks++; if ({o_RegWrite, o_ALUSrc, o_MemRead, o_MemWrite} !== 4'b1100) begin
      errors++; $display("FAIL addi_ctrl: got rw/alusrc/mr/mw=%b want 1100", {o_RegWrite, o_ALUSrc, o_MemRead, o_MemWrite}); end
    idle(2);
  endtask

  task automatic test_load_use();
    i_instruction = 32'h8C020000; i_PC = 32'd20;   // LW r2, 0(r0)
    tick();
    i_instruction = 32'h00421821; i_PC = 32'd21;   // ADDU r3, r2, r2
    tick();
    i_instruction = 32'h0;
    #1;
    checks++; if (o_PC_write !== 1'b0) begin errors++; $display("FAIL lu_stall: got pc_write=%b want 0", o_PC_write); end
    checks++; if ({o_MemRead, o_MemtoReg, o_rd_dst} !== 7'b1100010) begin
      errors++; $display("FAIL lu_lw: got mr=%b m2r=%b rd=%0d want 1 1 2", o_MemRead, o_MemtoReg, o_rd_dst); end
    tick();
    checks++; if ({o_RegWrite, o_MemRead} !== 2'b00) begin errors++; $display("FAIL lu_bubble: got rw=%b mr=%b want 0 0", o_RegWrite, o_MemRead); end
    checks++; if (o_PC_write !== 1'b1) begin errors++; $display("FAIL lu_one_cycle: got pc_write=%b want 1", o_PC_write); end
    tick();
    checks++; if ({o_RegWrite, o_rd_dst, o_rs, o_rt} !== {1'b1, 5'd3, 5'd2, 5'd2}) begin
      errors++; $display("FAIL lu_addu: got rw=%b rd=%0d rs=%0d rt=%0d want 1 3 2 2", o_RegWrite, o_rd_dst, o_rs, o_rt); end
    idle(2);
  endtask

  task automatic test_branch();
    i_instruction = 32'h10000003; i_PC = 32'd10;   // BEQ r0, r0, +3
    tick();
    i_instruction = 32'h20010005; i_PC = 32'd11;   // ADDI r1, r0, 5 (to be flushed)
    #1;
    checks++; if (o_PCSrc !== 1'b1) begin errors++; $display("FAIL beq_pcsrc: got %b want 1", o_PCSrc); end
    checks++; if (o_PC_branch !== 32'd14) begin errors++; $display("FAIL beq_target: got %0d want 14", o_PC_branch); end
    tick();
    i_instruction = 32'h0;
    #1;
    checks++; if (o_PCSrc !== 1'b0) begin errors++; $display("FAIL beq_one_cycle: got pcsrc=%b want 0", o_PCSrc); end
    tick();
    checks++; if ({o_RegWrite, o_ALUSrc, o_imm} !== 34'h0) begin
      errors++; $display("FAIL beq_flush: got rw=%b alusrc=%b imm=%h want 0 0 0", o_RegWrite, o_ALUSrc, o_imm); end
    i_instruction = 32'h14000003; i_PC = 32'd30;   // BNE r0, r0, +3 (not taken)
    tick();
    i_instruction = 32'h0;
    #1;
    checks++; if (o_PCSrc !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got pcsrc=%b want 0", o_PCSrc); end
    idle(2);
  endtask

  task automatic test_bypass();
    i_instruction = 32'h00A03021; i_PC = 32'd40;   // ADDU r6, r5, r0
    tick();
    i_instruction = 32'h0;
    i_WB_RegWrite = 1'b1; i_WB_rd = 5'd5; i_WB_data = 32'hCAFE;
    tick();
    i_WB_RegWrite = 1'b0;
    checks++; if (o_rs_data !== 32'hCAFE) begin errors++; $display("FAIL bypass_rs: got %h want cafe", o_rs_data); end
    i_instruction = 32'h00053821;                  // ADDU r7, r0, r5
    tick();
    i_instruction = 32'h0;
    tick();
    checks++; if (o_rt_data !== 32'hCAFE) begin errors++; $display("FAIL regfile_persist: got %h want cafe", o_rt_data); end
    idle(2);
  endtask

  task automatic test_branch_dependency();
    i_instruction = 32'h20050007; i_PC = 32'd50;   // ADDI r5, r0, 7
    tick();
    i_instruction = 32'h10A00002; i_PC = 32'd51;   // BEQ r5, r0, +2
    tick();
    i_instruction = 32'h0;
    i_WB_RegWrite = 1'b1; i_WB_rd = 5'd9; i_WB_data = 32'h1234;
    #1;
    checks++; if ({o_PC_write, o_PCSrc} !== 2'b00) begin
      errors++; $display("FAIL brdep_idex: got pc_write=%b pcsrc=%b want 0 0", o_PC_write, o_PCSrc); end
    tick();
    i_WB_RegWrite = 1'b0;
    i_EXMEM_RegWrite = 1'b1; i_EXMEM_rd = 5'd5;
    #1;
    checks++; if ({o_PC_write, o_RegWrite} !== 2'b00) begin
      errors++; $display("FAIL brdep_exmem: got pc_write=%b rw=%b want 0 0", o_PC_write, o_RegWrite); end
    tick();
    i_EXMEM_RegWrite = 1'b0;
    i_WB_RegWrite = 1'b1; i_WB_rd = 5'd5; i_WB_data = 32'd7;
    #1;
    checks++; if ({o_PC_write, o_PCSrc} !== 2'b10) begin
      errors++; $display("FAIL brdep_release: got pc_write=%b pcsrc=%b want 1 0", o_PC_write, o_PCSrc); end
    tick();
    i_WB_RegWrite = 1'b0;
    i_instruction = 32'h01205021;                  // ADDU r10, r9, r0
    tick();
    i_instruction = 32'h0;
    tick();
    checks++; if (o_rs_data !== 32'h1234) begin errors++; $display("FAIL stall_wb_commit: got %h want 1234", o_rs_data); end
    idle(2);
  endtask

  task automatic test_jumps();
    i_instruction = 32'h0C000040; i_PC = 32'd7;    // JAL 0x40
    tick();
    i_instruction = 32'h0;
    #1;
    checks++; if ({o_PCSrc, o_PC_branch} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL jal_target: got pcsrc=%b target=%h want 1 40", o_PCSrc, o_PC_branch); end
    tick();
    checks++; if ({o_rd_dst, o_PC_link, o_RegWrite, o_ALUSrc} !== {5'd31, 32'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL jal_link: got rd=%0d link=%0d rw=%b alusrc=%b want 31 8 1 1", o_rd_dst, o_PC_link, o_RegWrite, o_ALUSrc); end
    i_instruction = 32'h00000821;                  // ADDU r1, r0, r0
    tick();
    i_instruction = 32'h0;
    i_WB_RegWrite = 1'b1; i_WB_rd = 5'd0; i_WB_data = 32'hDEAD;
    tick();
    i_WB_RegWrite = 1'b0;
    checks++; if ({o_rs_data, o_rt_data} !== 64'h0) begin
      errors++; $display("FAIL r0_hardwired: got %h %h want 0 0", o_rs_data, o_rt_data); end
    idle(2);
    i_instruction = 32'h01200008; i_PC = 32'd60;   // JR r9
    tick();
    i_instruction = 32'h0;
    #1;
    checks++; if ({o_PCSrc, o_PC_branch} !== {1'b1, 32'h1234}) begin
      errors++; $display("FAIL jr_target: got pcsrc=%b target=%h want 1 1234", o_PCSrc, o_PC_branch); end
    idle(2);
  endtask

  task automatic test_reset_mid_stall();
    i_instruction = 32'h8C020000; i_PC = 32'd70;
    tick();
    i_instruction = 32'h00421821;
    tick();
    i_instruction = 32'h0;
    #1;
    checks++; if (o_PC_write !== 1'b0) begin errors++; $display("FAIL rms_stall: got pc_write=%b want 0", o_PC_write); end
    i_rst = 1'b0;
    #1;
    checks++; if ({o_PC_write, o_PCSrc} !== 2'b10) begin
      errors++; $display("FAIL rms_immediate: got pc_write=%b pcsrc=%b want 1 0", o_PC_write, o_PCSrc); end
    tick();
    i_rst = 1'b1;
    checks++; if ({o_MemRead, o_RegWrite} !== 2'b00) begin
      errors++; $display("FAIL rms_idex: got mr=%b rw=%b want 0 0", o_MemRead, o_RegWrite); end
    i_instruction = 32'h01205021;                  // ADDU r10, r9, r0 after reset
    tick();
    i_instruction = 32'h0;
    tick();
    checks++; if (o_rs_data !== 32'h0) begin errors++; $display("FAIL rms_rf_cleared: got %h want 0", o_rs_data); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_branch();
    test_bypass();
    test_branch_dependency();
    test_jumps();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
